// File: rtl/reg_file_sequencer_if.sv
// Command bus between the instruction source, the sequencer and the 4x8 register file.
// The sequencer side uses the master modport; the source/file side uses slave.
interface reg_file_sequencer_if;
    logic [7:0] in_Instr;
    logic       in_Valid;
    logic       out_Ready;
    logic       rf_Read_Write;
    logic [1:0] rf_Read_Register1;
    logic [1:0] rf_Read_Register2;
    logic [1:0] rf_Write_Register;
    logic [7:0] rf_Write_Data;
    logic [7:0] rf_Read_Data1;
    logic [7:0] rf_Read_Data2;

    modport master (
        input  in_Instr,
        input  in_Valid,
        input  rf_Read_Data1,
        input  rf_Read_Data2,
        output out_Ready,
        output rf_Read_Write,
        output rf_Read_Register1,
        output rf_Read_Register2,
        output rf_Write_Register,
        output rf_Write_Data
    );

    modport slave (
        output in_Instr,
        output in_Valid,
        output rf_Read_Data1,
        output rf_Read_Data2,
        input  out_Ready,
        input  rf_Read_Write,
        input  rf_Read_Register1,
        input  rf_Read_Register2,
        input  rf_Write_Register,
        input  rf_Write_Data
    );
endinterface

// File: rtl/reg_file_sequencer.sv
// Command-side master for the 4x8 register file: one instruction per handshake,
// sequenced READ -> EXEC -> WRITE with a local 8-bit ADD/SUB/LI/DISP datapath.
module reg_file_sequencer #(
    parameter bit SATURATE = 1'b0
) (
    input  logic                 input_Clock,
    input  logic                 input_Reset,
    reg_file_sequencer_if.master bus,
    output logic [7:0]           out_Display,
    output logic                 out_Overflow,
    output logic                 out_Done
);
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LI   = 2'b10;
    localparam logic [1:0] OP_DISP = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_EXEC  = 2'b10,
        S_WRITE = 2'b11
    } state_t;

    state_t state;

    // Returns {carry, sum}; the carry is reported even when the sum is clamped.
    function automatic logic [DATA_W:0] add_sat(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (SATURATE && sum[DATA_W])
            sum[DATA_W-1:0] = '1;
        return sum;
    endfunction

    // Returns {borrow, difference}; bit DATA_W of the extended difference is the borrow.
    function automatic logic [DATA_W:0] sub_sat(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [DATA_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (SATURATE && diff[DATA_W])
            diff[DATA_W-1:0] = '0;
        return diff;
    endfunction

    // Instruction register: pure data, loaded only on an accepted handshake.
    logic [7:0] instr_p0;

    always_ff @(posedge input_Clock) begin
        if (bus.out_Ready && bus.in_Valid)
            instr_p0 <= bus.in_Instr;
    end

    logic [1:0]              op;
    logic [1:0]              rd;
    logic signed [3:0]       imm;
    logic signed [DATA_W-1:0] imm_ext;

    assign op      = instr_p0[7:6];
    assign rd      = instr_p0[1:0];
    assign imm     = instr_p0[5:2];
    assign imm_ext = {{(DATA_W-4){imm[3]}}, imm};

    // EXEC datapath: read data from the file is valid for this whole state.
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;

    always_comb begin
        alu_res = imm_ext;
        alu_ovf = out_Overflow;
        case (op)
            OP_ADD:  {alu_ovf, alu_res} = add_sat(bus.rf_Read_Data1, bus.rf_Read_Data2);
            OP_SUB:  {alu_ovf, alu_res} = sub_sat(bus.rf_Read_Data1, bus.rf_Read_Data2);
            default: ;
        endcase
    end

    // Sequencer FSM; every bus output is registered on the transition into its state.
    always_ff @(posedge input_Clock or posedge input_Reset) begin
        if (input_Reset) begin
            state                 <= S_IDLE;
            bus.out_Ready         <= 1'b1;
            bus.rf_Read_Write     <= 1'b0;
            bus.rf_Read_Register1 <= 2'b00;
            bus.rf_Read_Register2 <= 2'b00;
            bus.rf_Write_Register <= 2'b00;
            bus.rf_Write_Data     <= '0;
            out_Display           <= '0;
            out_Overflow          <= 1'b0;
            out_Done              <= 1'b0;
        end else begin
            out_Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.out_Ready && bus.in_Valid) begin
                        state                 <= S_READ;
                        bus.out_Ready         <= 1'b0;
                        bus.rf_Read_Register1 <= bus.in_Instr[5:4];
                        bus.rf_Read_Register2 <= bus.in_Instr[3:2];
                    end
                end
                S_READ: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    bus.rf_Read_Register1 <= 2'b00;
                    bus.rf_Read_Register2 <= 2'b00;
                    if (op == OP_DISP) begin
                        state         <= S_IDLE;
                        out_Display   <= bus.rf_Read_Data1;
                        out_Done      <= 1'b1;
                        bus.out_Ready <= 1'b1;
                    end else begin
                        state                 <= S_WRITE;
                        out_Overflow          <= alu_ovf;
                        bus.rf_Read_Write     <= 1'b1;
                        bus.rf_Write_Register <= rd;
                        bus.rf_Write_Data     <= alu_res;
                    end
                end
                S_WRITE: begin
                    state                 <= S_IDLE;
                    out_Done              <= 1'b1;
                    bus.out_Ready         <= 1'b1;
                    bus.rf_Read_Write     <= 1'b0;
                    bus.rf_Write_Register <= 2'b00;
                    bus.rf_Write_Data     <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_sequencer.sv
// Bench for reg_file_sequencer: a wrapping and a saturating instance share one instruction
// stream, each driving its own register-file model; results are checked against a scoreboard.
module tb_reg_file_sequencer;
    logic input_Clock = 1'b0;
    logic input_Reset;
    logic [7:0] instr;
    logic       valid;

    always #5 input_Clock = ~input_Clock;

    reg_file_sequencer_if bus_w ();
    reg_file_sequencer_if bus_s ();

    logic [7:0] disp_w, disp_s;
    logic       ovf_w, ovf_s, done_w, done_s;

    assign bus_w.in_Instr = instr;
    assign bus_w.in_Valid = valid;
    assign bus_s.in_Instr = instr;
    assign bus_s.in_Valid = valid;

    reg_file_sequencer #(.SATURATE(1'b0)) u_wrap (
        .input_Clock  (input_Clock),
        .input_Reset  (input_Reset),
        .bus          (bus_w),
        .out_Display  (disp_w),
        .out_Overflow (ovf_w),
        .out_Done     (done_w)
    );

    reg_file_sequencer #(.SATURATE(1'b1)) u_sat (
        .input_Clock  (input_Clock),
        .input_Reset  (input_Reset),
        .bus          (bus_s),
        .out_Display  (disp_s),
        .out_Overflow (ovf_s),
        .out_Done     (done_s)
    );

    // Register-file models: registered reads, writes on rf_Read_Write; every write is logged.
    logic [7:0] rf_w [4] = '{default: 8'h00};
    logic [7:0] rf_s [4] = '{default: 8'h00};
    logic [7:0] rdw1 = 8'h00, rdw2 = 8'h00, rds1 = 8'h00, rds2 = 8'h00;
    logic [9:0] wq_w [$];
    logic [9:0] wq_s [$];

    always @(posedge input_Clock) begin
        if (bus_w.rf_Read_Write) begin
            rf_w[bus_w.rf_Write_Register] <= bus_w.rf_Write_Data;
            wq_w.push_back({bus_w.rf_Write_Register, bus_w.rf_Write_Data});
        end else begin
            rdw1 <= rf_w[bus_w.rf_Read_Register1];
            rdw2 <= rf_w[bus_w.rf_Read_Register2];
        end
        if (bus_s.rf_Read_Write) begin
            rf_s[bus_s.rf_Write_Register] <= bus_s.rf_Write_Data;
            wq_s.push_back({bus_s.rf_Write_Register, bus_s.rf_Write_Data});
        end else begin
            rds1 <= rf_s[bus_s.rf_Read_Register1];
            rds2 <= rf_s[bus_s.rf_Read_Register2];
        end
    end

    assign bus_w.rf_Read_Data1 = rdw1;
    assign bus_w.rf_Read_Data2 = rdw2;
    assign bus_s.rf_Read_Data1 = rds1;
    assign bus_s.rf_Read_Data2 = rds2;

    typedef struct packed {
        logic [3:0] lat;
        logic       wr;
        logic [1:0] rd;
        logic [7:0] data_w;
        logic [7:0] data_s;
        logic       ovf_w;
        logic       ovf_s;
        logic [7:0] disp_w;
        logic [7:0] disp_s;
    } exp_t;

    typedef struct packed {
        logic [7:0] lat;
        logic       done_s;
        logic [7:0] nw;
        logic [9:0] ev_w;
        logic [9:0] ev_s;
        logic       ovf_w;
        logic       ovf_s;
        logic [7:0] disp_w;
        logic [7:0] disp_s;
    } obs_t;

    exp_t       sbq [$];
    logic [7:0] m_rf [2][4];
    logic       m_ovf [2];
    logic [7:0] m_disp [2];
    int         n_chk = 0;
    int         n_fail = 0;

    // Architectural model; index 0 wraps, index 1 saturates.
    task automatic sb_push(input logic [7:0] ins);
        exp_t       e;
        logic [8:0] r;
        logic [7:0] a, b;
        logic [7:0] res [2];
        for (int k = 0; k < 2; k++) begin
            a = m_rf[k][ins[5:4]];
            b = m_rf[k][ins[3:2]];
            res[k] = 8'h00;
            case (ins[7:6])
                2'b00: begin
                    r = {1'b0, a} + {1'b0, b};
                    m_ovf[k] = r[8];
                    res[k] = (k == 1 && r[8]) ? 8'hFF : r[7:0];
                end
                2'b01: begin
                    r = {1'b0, a} - {1'b0, b};
                    m_ovf[k] = (a < b);
                    res[k] = (k == 1 && a < b) ? 8'h00 : r[7:0];
                end
                2'b10:   res[k] = {{4{ins[5]}}, ins[5:2]};
                default: m_disp[k] = a;
            endcase
            if (ins[7:6] != 2'b11)
                m_rf[k][ins[1:0]] = res[k];
        end
        e.lat    = (ins[7:6] == 2'b11) ? 4'd3 : 4'd4;
        e.wr     = (ins[7:6] != 2'b11);
        e.rd     = ins[1:0];
        e.data_w = res[0];
        e.data_s = res[1];
        e.ovf_w  = m_ovf[0];
        e.ovf_s  = m_ovf[1];
        e.disp_w = m_disp[0];
        e.disp_s = m_disp[1];
        sbq.push_back(e);
    endtask

    // Issues one instruction, waits (bounded) for Done and gathers what the DUTs did.
    task automatic run_one(input logic [7:0] ins, output obs_t o);
        o = '0;
        o.lat  = 8'hFF;
        o.ev_w = 'x;
        o.ev_s = 'x;
        sb_push(ins);
        @(negedge input_Clock);
        instr = ins;
        valid = 1'b1;
        for (int i = 0; i < 20 && !bus_w.out_Ready; i++) @(negedge input_Clock);
        @(negedge input_Clock);
        valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (done_w) begin
                o.lat    = 8'(n);
                o.done_s = done_s;
                break;
            end
            @(negedge input_Clock);
        end
        o.nw = 8'(wq_w.size());
        if (wq_w.size() > 0) o.ev_w = wq_w.pop_front();
        if (wq_s.size() > 0) o.ev_s = wq_s.pop_front();
        wq_w.delete();
        wq_s.delete();
        o.ovf_w  = ovf_w;
        o.ovf_s  = ovf_s;
        o.disp_w = disp_w;
        o.disp_s = disp_s;
    endtask

    task automatic test_reset();
        input_Reset = 1'b1;
        valid = 1'b0;
        instr = 8'h00;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) m_rf[k][i] = 8'h00;
            m_ovf[k] = 1'b0;
            m_disp[k] = 8'h00;
        end
        repeat (3) @(negedge input_Clock);
        n_chk++;
        if (bus_w.out_Ready !== 1'b1 || bus_s.out_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready actual %b/%b required 1/1", bus_w.out_Ready, bus_s.out_Ready);
        end
        n_chk++;
        if ({bus_w.rf_Read_Write, bus_w.rf_Read_Register1, bus_w.rf_Read_Register2,
             bus_w.rf_Write_Register, bus_w.rf_Write_Data} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_rf_bus actual rw=%b a=%0d b=%0d w=%0d d=%h required all 0",
                     bus_w.rf_Read_Write, bus_w.rf_Read_Register1, bus_w.rf_Read_Register2,
                     bus_w.rf_Write_Register, bus_w.rf_Write_Data);
        end
        n_chk++;
        if (disp_w !== 8'h00 || ovf_w !== 1'b0 || done_w !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status actual disp=%h ovf=%b done=%b required 00/0/0", disp_w, ovf_w, done_w);
        end
        input_Reset = 1'b0;
        @(negedge input_Clock);
        n_chk++;
        if (bus_w.out_Ready !== 1'b1 || done_w !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle actual ready=%b done=%b required 1/0", bus_w.out_Ready, done_w);
        end
    endtask

    task automatic test_li();
        logic [7:0] prog [2] = '{8'h95, 8'hB6};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            run_one(prog[i], o);
            e = sbq.pop_front();
            n_chk++;
            if (o.lat !== {4'h0, e.lat} || o.done_s !== 1'b1) begin
                n_fail++;
                $display("FAIL li_latency[%0d] actual %0d (sat done %b) required %0d", i, o.lat, o.done_s, e.lat);
            end
            n_chk++;
            if (o.nw !== 8'd1 || o.ev_w !== {e.rd, e.data_w} || o.ev_s !== {e.rd, e.data_s}) begin
                n_fail++;
                $display("FAIL li_write[%0d] actual n=%0d %h/%h required 1 %h/%h", i, o.nw, o.ev_w, o.ev_s,
                         {e.rd, e.data_w}, {e.rd, e.data_s});
            end
            n_chk++;
            if (o.ovf_w !== e.ovf_w || o.disp_w !== e.disp_w) begin
                n_fail++;
                $display("FAIL li_status[%0d] actual ovf=%b disp=%h required %b/%h", i, o.ovf_w, o.disp_w, e.ovf_w, e.disp_w);
            end
        end
    endtask

    task automatic test_alu();
        logic [7:0] prog [4] = '{8'h1B, 8'h58, 8'hC0, 8'h14};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            run_one(prog[i], o);
            e = sbq.pop_front();
            n_chk++;
            if (o.lat !== {4'h0, e.lat} || o.done_s !== 1'b1) begin
                n_fail++;
                $display("FAIL alu_latency[%0d] actual %0d (sat done %b) required %0d", i, o.lat, o.done_s, e.lat);
            end
            n_chk++;
            if (o.nw !== {7'h0, e.wr}) begin
                n_fail++;
                $display("FAIL alu_write_count[%0d] actual %0d required %0d", i, o.nw, e.wr);
            end
            if (e.wr) begin
                n_chk++;
                if (o.ev_w !== {e.rd, e.data_w} || o.ev_s !== {e.rd, e.data_s}) begin
                    n_fail++;
                    $display("FAIL alu_write[%0d] actual %h/%h required %h/%h", i, o.ev_w, o.ev_s,
                             {e.rd, e.data_w}, {e.rd, e.data_s});
                end
            end
            n_chk++;
            if (o.ovf_w !== e.ovf_w || o.ovf_s !== e.ovf_s) begin
                n_fail++;
                $display("FAIL alu_overflow[%0d] actual %b/%b required %b/%b", i, o.ovf_w, o.ovf_s, e.ovf_w, e.ovf_s);
            end
            n_chk++;
            if (o.disp_w !== e.disp_w || o.disp_s !== e.disp_s) begin
                n_fail++;
                $display("FAIL alu_display[%0d] actual %h/%h required %h/%h", i, o.disp_w, o.disp_s, e.disp_w, e.disp_s);
            end
        end
    endtask

    // LI r1,4 then r1=r1+r1 six times: 04 .. 80, then 80+80 overflows.
    task automatic test_rd_eq_rs();
        obs_t o;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            run_one((i == 0) ? 8'h91 : 8'h15, o);
            e = sbq.pop_front();
            n_chk++;
            if (o.ev_w !== {e.rd, e.data_w} || o.ev_s !== {e.rd, e.data_s}) begin
                n_fail++;
                $display("FAIL rd_eq_rs_write[%0d] actual %h/%h required %h/%h", i, o.ev_w, o.ev_s,
                         {e.rd, e.data_w}, {e.rd, e.data_s});
            end
            n_chk++;
            if (o.ovf_w !== e.ovf_w || o.ovf_s !== e.ovf_s || o.lat !== {4'h0, e.lat}) begin
                n_fail++;
                $display("FAIL rd_eq_rs_status[%0d] actual ovf=%b/%b lat=%0d required %b/%b %0d", i,
                         o.ovf_w, o.ovf_s, o.lat, e.ovf_w, e.ovf_s, e.lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] prog [3] = '{8'h9F, 8'h76, 8'hE0};
        int         acc [$];
        int         idx = 0;
        int         ndone = 0;
        logic [9:0] ev;
        exp_t       e;
        @(negedge input_Clock);
        instr = prog[0];
        valid = 1'b1;
        for (int k = 0; k < 40 && ndone < 3; k++) begin
            if (done_w) begin
                e = sbq.pop_front();
                ndone++;
                n_chk++;
                if (k - acc[ndone-1] != int'(e.lat)) begin
                    n_fail++;
                    $display("FAIL b2b_latency[%0d] actual %0d required %0d", ndone - 1, k - acc[ndone-1], e.lat);
                end
                n_chk++;
                if (e.wr) begin
                    ev = (wq_w.size() > 0) ? wq_w.pop_front() : 'x;
                    if (ev !== {e.rd, e.data_w}) begin
                        n_fail++;
                        $display("FAIL b2b_write[%0d] actual %h required %h", ndone - 1, ev, {e.rd, e.data_w});
                    end
                end else if (disp_w !== e.disp_w || disp_s !== e.disp_s || wq_w.size() != 0) begin
                    n_fail++;
                    $display("FAIL b2b_display actual %h/%h pending=%0d required %h/%h 0", disp_w, disp_s,
                             wq_w.size(), e.disp_w, e.disp_s);
                end
                n_chk++;
                if (ovf_w !== e.ovf_w || ovf_s !== e.ovf_s) begin
                    n_fail++;
                    $display("FAIL b2b_overflow[%0d] actual %b/%b required %b/%b", ndone - 1, ovf_w, ovf_s, e.ovf_w, e.ovf_s);
                end
            end
            if (valid && bus_w.out_Ready) begin
                acc.push_back(k);
                sb_push(instr);
                idx++;
            end
            @(negedge input_Clock);
            if (idx < 3) instr = prog[idx];
            else         valid = 1'b0;
        end
        wq_w.delete();
        wq_s.delete();
        n_chk++;
        if (ndone != 3 || acc.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count actual done=%0d accepts=%0d required 3/3", ndone, acc.size());
        end else begin
            n_chk++;
            if (acc[0] != 0 || acc[1] != 4 || acc[2] != 8) begin
                n_fail++;
                $display("FAIL b2b_accept_cycles actual %0d,%0d,%0d required 0,4,8", acc[0], acc[1], acc[2]);
            end
        end
    endtask

    // Reset pulse while ADD r3=r1+r1 is in WRITE: no write, no Done, Ready back at once.
    task automatic test_reset_mid_write();
        int   ndone = 0;
        obs_t o;
        exp_t e;
        @(negedge input_Clock);
        instr = 8'h17;
        valid = 1'b1;
        @(negedge input_Clock);
        valid = 1'b0;
        repeat (2) @(negedge input_Clock);
        n_chk++;
        if (bus_w.rf_Read_Write !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_in_write actual rw=%b required 1", bus_w.rf_Read_Write);
        end
        #1 input_Reset = 1'b1;
        #1;
        n_chk++;
        if (bus_w.out_Ready !== 1'b1 || bus_w.rf_Read_Write !== 1'b0 || bus_s.rf_Read_Write !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async actual ready=%b rw=%b/%b required 1 0/0", bus_w.out_Ready,
                     bus_w.rf_Read_Write, bus_s.rf_Read_Write);
        end
        @(negedge input_Clock);
        input_Reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_ovf[k] = 1'b0;
            m_disp[k] = 8'h00;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge input_Clock);
            if (done_w || done_s) ndone++;
        end
        n_chk++;
        if (ndone != 0 || bus_w.out_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_no_done actual dones=%0d ready=%b required 0/1", ndone, bus_w.out_Ready);
        end
        n_chk++;
        if (wq_w.size() != 0 || wq_s.size() != 0 || rf_w[3] !== m_rf[0][3] || rf_s[3] !== m_rf[1][3]) begin
            n_fail++;
            $display("FAIL abort_no_write actual writes=%0d/%0d r3=%h/%h required 0/0 %h/%h", wq_w.size(),
                     wq_s.size(), rf_w[3], rf_s[3], m_rf[0][3], m_rf[1][3]);
        end
        run_one(8'hF0, o);
        e = sbq.pop_front();
        n_chk++;
        if (o.lat !== {4'h0, e.lat} || o.disp_w !== e.disp_w || o.disp_s !== e.disp_s || o.ovf_w !== e.ovf_w) begin
            n_fail++;
            $display("FAIL abort_recover actual lat=%0d disp=%h/%h ovf=%b required %0d %h/%h %b", o.lat,
                     o.disp_w, o.disp_s, o.ovf_w, e.lat, e.disp_w, e.disp_s, e.ovf_w);
        end
    endtask

    initial begin
        test_reset();
        test_li();
        test_alu();
        test_rd_eq_rs();
        test_back_to_back();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the test sequence completed");
        $fatal(1, "watchdog");
    end
endmodule
